// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU datapath blocks (multiplier, divider).
//   - ALU function codes carried on the 6-bit Signal bus.
//   - Divider FSM state encoding.
//   - Default datapath width.
// The divider's optional signed mode is enabled with the DIV_SIGNED_EN macro.
package alu_pkg;

  localparam int WIDTH = 32;

  // ALU function codes
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_BEQ   = 6'b000100;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // Divider controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/divider_div_step.sv
// div_step: one combinational restoring-division step.
//   r_in  : current partial remainder (always < d_in)
//   q_in  : current quotient/dividend shift register
//   d_in  : divisor
//   r_out : partial remainder after the step
//   q_out : quotient register after the step (new quotient bit shifted in at LSB)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Shift the next dividend bit into the remainder and try subtracting the divisor.
  // The remainder entering a step is below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the kept remainder always fits back into WIDTH bits.
  always_comb begin
    shifted_s = {r_in, q_in[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, d_in};
    if (trial_s[WIDTH] == 1'b0) begin
      r_out = trial_s[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      r_out = shifted_s[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// divider: sequential restoring divider for DIVU (and DIV when DIV_SIGNED_EN is defined).
//   clk         : system clock, rising edge
//   reset       : asynchronous active-low reset
//   Signal      : ALU function code; DIVU_CODE in IDLE starts a divide
//   dividend    : numerator, captured at start
//   divisor     : denominator, captured at start
//   dataout     : {remainder, quotient}; holds the last result
//   busy        : high while iterating (RUN)
//   done        : one-cycle pulse after dataout is updated
//   div_by_zero : last completed operation had divisor == 0
// Optional macro DIV_SIGNED_EN: DIV_CODE starts a signed divide with a sign fixup
// cycle before done. Without it DIV_CODE is ignored.
module divider
  import alu_pkg::*;
#(
  parameter int         WIDTH     = alu_pkg::WIDTH,
  parameter logic [5:0] DIVU_CODE = FN_DIVU,
  parameter logic [5:0] DIV_CODE  = FN_DIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Signal,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] dataout,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  div_state_e         state_q,   state_d;
  logic [WIDTH-1:0]   r_q,       r_d;
  logic [WIDTH-1:0]   q_q,       q_d;
  logic [WIDTH-1:0]   d_q,       d_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic [2*WIDTH-1:0] dataout_q, dataout_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic               dbz_q,     dbz_d;
  logic [WIDTH-1:0]   step_r_s;
  logic [WIDTH-1:0]   step_q_s;
`ifdef DIV_SIGNED_EN
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               fix_q,     fix_d;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    abs_val = x[WIDTH-1] ? -x : x;
  endfunction
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (d_q),
    .r_out (step_r_s),
    .q_out (step_q_s)
  );

  // Next-state and datapath control for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    d_d       = d_q;
    count_d   = count_q;
    dataout_d = dataout_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    fix_d     = fix_q;
`endif
    case (state_q)
      IDLE: begin
        case (Signal)
          DIVU_CODE: begin
            q_d     = dividend;
            d_d     = divisor;
            r_d     = ZERO_W;
            count_d = CNT_ZERO;
            dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            fix_d     = 1'b0;
`endif
            if (divisor == ZERO_W) begin
              // No iteration needed: the result is fixed by definition.
              state_d   = DONE;
              dataout_d = {dividend, ONES_W};
              dbz_d     = 1'b1;
              done_d    = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
          DIV_CODE: begin
`ifdef DIV_SIGNED_EN
            // Divide magnitudes; signs are reapplied in the fixup cycle.
            q_d       = abs_val(dividend);
            d_d       = abs_val(divisor);
            r_d       = ZERO_W;
            count_d   = CNT_ZERO;
            dbz_d     = 1'b0;
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
            if (divisor == ZERO_W) begin
              state_d   = DONE;
              fix_d     = 1'b0;
              dataout_d = {dividend, ONES_W};
              dbz_d     = 1'b1;
              done_d    = 1'b1;
            end else begin
              state_d = RUN;
              fix_d   = 1'b1;
            end
`else
            // Signed divide not built: treated as a non-start code.
            state_d = IDLE;
`endif
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
      RUN: begin
        r_d     = step_r_s;
        q_d     = step_q_s;
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          state_d = DONE;
`ifdef DIV_SIGNED_EN
          if (fix_q) begin
            // Result is published by the fixup cycle in DONE.
            done_d = 1'b0;
          end else begin
            dataout_d = {step_r_s, step_q_s};
            done_d    = 1'b1;
          end
`else
          dataout_d = {step_r_s, step_q_s};
          done_d    = 1'b1;
`endif
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
`ifdef DIV_SIGNED_EN
        if (fix_q) begin
          // Fixup: negate the quotient on sign mismatch; remainder follows the dividend.
          // The most-negative / -1 case falls out naturally as 0x80..0 with remainder 0.
          dataout_d = {(neg_rem_q ? -r_q : r_q), (neg_quo_q ? -q_q : q_q)};
          done_d    = 1'b1;
          fix_d     = 1'b0;
          state_d   = DONE;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State and output registers; reset clears everything, discarding any operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      r_q       <= ZERO_W;
      q_q       <= ZERO_W;
      d_q       <= ZERO_W;
      count_q   <= CNT_ZERO;
      dataout_q <= {(2*WIDTH){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      fix_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      d_q       <= d_d;
      count_q   <= count_d;
      dataout_q <= dataout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      fix_q     <= fix_d;
`endif
    end
  end

  assign dataout     = dataout_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// tb_divider: self-checking bench for divider. Directed cases plus random operands,
// compared with an arithmetic reference model (/ and % on the captured operands).
module tb_divider;

  localparam logic [5:0] C_DIVU = 6'b011011;
  localparam logic [5:0] C_DIV  = 6'b011010;
  localparam logic [5:0] C_NOP  = 6'b100000;

  logic        clk;
  logic        reset;
  logic [5:0]  Signal;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] dataout;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_vec;
  int n_err;

  divider dut (
    .clk         (clk),
    .reset       (reset),
    .Signal      (Signal),
    .dividend    (dividend),
    .divisor     (divisor),
    .dataout     (dataout),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // {remainder, quotient} from plain arithmetic on the operands.
  function automatic logic [63:0] ref_result(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  // Start one operation, watch 60 cycles, check result, latency, busy time and pulse count.
  task automatic run_op(input string tag, input logic [5:0] code, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    bit          sgn;
    int          first_done;
    int          n_done;
    int          n_busy;
    int          exp_lat;
    int          exp_busy;
    logic [63:0] exp;
    sgn        = (code == C_DIV);
    exp        = ref_result(sgn, a, b);
    exp_lat    = (b == 32'd0) ? 1 : (sgn ? 34 : 33);
    exp_busy   = (b == 32'd0) ? 0 : 32;
    first_done = 0;
    n_done     = 0;
    n_busy     = 0;
    @(negedge clk);
    Signal   = code;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    // Operands are free to change after the start edge.
    Signal   = C_NOP;
    dividend = $urandom;
    divisor  = $urandom;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = n;
          check({tag, "/data"}, dataout, exp);
          check({tag, "/dbz"}, {63'd0, div_by_zero}, {63'd0, (b == 32'd0)});
        end
      end
      if (busy) n_busy++;
      if (inject && n >= 2 && n <= 6) begin
        Signal   = C_DIVU;
        dividend = $urandom;
        divisor  = $urandom_range(1, 50);
      end else begin
        Signal = C_NOP;
      end
    end
    check({tag, "/latency"}, 64'(first_done), 64'(exp_lat));
    check({tag, "/pulses"}, 64'(n_done), 64'd1);
    check({tag, "/busy_cycles"}, 64'(n_busy), 64'(exp_busy));
    check({tag, "/hold"}, dataout, exp);
  endtask

  initial begin
    logic [63:0] held;
    int          n_done;
    int          n_busy;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  code;
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b0;
    Signal   = C_NOP;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset/data", dataout, 64'd0);
    check("reset/flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    reset = 1'b1;

    run_op("basic_100_7", C_DIVU, 32'd100, 32'd7, 1'b0);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    Signal   = C_DIVU;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(negedge clk);
    Signal = C_NOP;
    repeat (9) @(negedge clk);
    check("midrun/busy_before", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("midrun/data", dataout, 64'd0);
    check("midrun/flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(negedge clk);
    reset  = 1'b1;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("midrun/no_done", 64'(n_done), 64'd0);
    check("midrun/no_busy", 64'(n_busy), 64'd0);

    run_op("max_by_1", C_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("5_by_9", C_DIVU, 32'd5, 32'd9, 1'b0);
    run_op("msb_by_msb", C_DIVU, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("dbz_1234", C_DIVU, 32'd1234, 32'd0, 1'b0);
    run_op("after_dbz_10_3", C_DIVU, 32'd10, 32'd3, 1'b0);
    run_op("ignored_restart", C_DIVU, 32'd1000, 32'd10, 1'b1);

`ifdef DIV_SIGNED_EN
    run_op("s_m7_2", C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("s_7_m2", C_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("s_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("s_dbz", C_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
`else
    // DIV_CODE is not a start code in this build.
    held = dataout;
    @(negedge clk);
    Signal   = C_DIV;
    dividend = 32'd77;
    divisor  = 32'd5;
    @(negedge clk);
    Signal = C_NOP;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      if (busy) n_busy++;
      @(negedge clk);
    end
    check("div_code_ignored/done", 64'(n_done), 64'd0);
    check("div_code_ignored/busy", 64'(n_busy), 64'd0);
    check("div_code_ignored/data", dataout, held);
`endif

    for (int k = 0; k < 60; k++) begin
      a = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'd0;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = a >> $urandom_range(0, 3);
      endcase
`ifdef DIV_SIGNED_EN
      if ($urandom_range(0, 1) == 0) begin
        code = C_DIV;
        if ($urandom_range(0, 1) == 0) a = -a;
        if ($urandom_range(0, 1) == 0) b = -b;
      end else begin
        code = C_DIVU;
      end
`else
      code = C_DIVU;
`endif
      run_op($sformatf("rand%0d", k), code, a, b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential unsigned 32-bit divider serving the DIVU instruction.
- Performs the inverse operation of the existing sequential multiplier and sits beside it in the ALU datapath.
- Produces a 64-bit {remainder, quotient} word for the HiLo register, so MFHI returns the remainder and MFLO returns the quotient.
- Started by the same 6-bit function Signal that drives the multiplier; runs one restoring-division step per clock.

Parameters:
- WIDTH, 32: operand width; dataout is 2*WIDTH.
- DIVU_CODE, 6'b011011: Signal value that starts an unsigned divide.
- DIV_CODE, 6'b011010: Signal value that starts a signed divide (used only with DIV_SIGNED_EN).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- Signal  input  6  function code; sampled every rising edge.
- dividend  input  WIDTH  numerator; captured on start.
- divisor  input  WIDTH  denominator; captured on start.
- dataout  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; holds the last result.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse when dataout has just been updated.
- div_by_zero  output  1  set when an operation with divisor==0 completes; held until the next accepted start.

Behaviour:
- Reset (reset==0, asynchronous):
  - state = IDLE, step counter = 0.
  - dataout = 0, busy = 0, done = 0, div_by_zero = 0.
  - Applies from any state, including mid-RUN; the in-flight operation is discarded and no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with Signal==DIVU_CODE: latch dividend into the quotient register Q and divisor into D. Clear the partial remainder R (WIDTH+1 bits), clear count, clear div_by_zero.
  - If divisor != 0, go to RUN.
  - If divisor == 0, go directly to DONE.
  - Any other Signal value: stay in IDLE.
- RUN: each edge performs one restoring step.
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}.
  - If T is non-negative: R = T and shift 1 into Q. Otherwise R = {R[WIDTH-1:0], Q[WIDTH-1]} and shift 0 into Q.
  - count increments each step. After the WIDTH-th step (count==WIDTH-1 at the edge), go to DONE and load dataout = {R[WIDTH-1:0], Q}.
- DONE: done = 1 for exactly one cycle, then unconditionally return to IDLE.
- Start requests:
  - Signal==DIVU_CODE in RUN or DONE is ignored; it is neither queued nor restarted.
  - The controller must issue a new start only after done.
- Latency:
  - Nonzero divisor: start sample edge, then WIDTH RUN edges; done is high in the cycle after the last step. For WIDTH=32, done is high 33 cycles after the start edge.
  - Zero divisor: done is high in the cycle after the start edge.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1.
- Operand capture: dividend and divisor may change after the start edge; the latched copies are used.
- Output hold: dataout is stable outside the update edge. It keeps the previous result through IDLE and RUN.
- Arithmetic: all unsigned. The quotient never overflows. Dividend < divisor gives quotient 0 and remainder = dividend.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Signal==DIV_CODE in IDLE starts a signed divide. The absolute values of both operands are latched, and the sign of the dividend and the XOR of the two signs are recorded.
  - After RUN, a fixup cycle in DONE loads the results: quotient is negated if the signs differ, and the remainder takes the dividend's sign. Signed latency is therefore one cycle longer than unsigned; done pulses after the fixup.
  - Overflow case -2^(WIDTH-1) / -1: quotient = 0x80000000, remainder = 0.
  - Signed divide by zero: quotient = all ones, remainder = dividend.
- Undefined: DIV_CODE is treated like any other non-start code and ignored.

Decomposition:
- Shared package (alu_pkg):
  - Function-code constants: DIVU, DIV, MULTU, MFHI, MFLO, alongside the existing AND/OR/ADD/SUB/SLT/SLL/BEQ codes.
  - Divider state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - WIDTH.
- Sub-module div_step: a combinational single restoring step.
  - Inputs: R, Q, D.
  - Outputs: next R and next Q.
  - The FSM and registers stay in divider.

Test Plan:
- Reset mid-RUN: start 100/7, pull reset low at cycle 10 -> dataout=0, busy=0, done=0 immediately; no done pulse for 40 cycles.
- Basic divide: start 100/7 -> busy for 32 cycles; done at cycle 33; dataout={32'd2, 32'd14}; div_by_zero=0.
- Extremes: 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}. 5/9 -> {5, 0}. 0x80000000/0x80000000 -> {0, 1}.
- Divide by zero: start 1234/0 -> done one cycle after start; dataout={1234, 0xFFFFFFFF}; div_by_zero=1. A following start 10/3 clears it and returns {1, 3}.
- Ignored restart: during RUN of 1000/10, drive Signal=DIVU with other operands for 5 cycles -> result remains {0, 100}; exactly one done pulse.
- DIV_SIGNED_EN builds: -7/2 -> {-1, -3}. 7/-2 -> {1, -3}. 0x80000000/-1 -> {0, 0x80000000}. Done at cycle 34. Without the macro, Signal=DIV_CODE causes no busy and no done.
